// File: rtl/multicycle_controller_if.sv
// multicycle_controller_if: control/status bundle between the multicycle controller and its datapath/memory
// master: controller side (takes instruction/mem_ready/cond_true, drives enables, selects, mem_req/mem_we, state, fault)
// slave: datapath/memory side (opposite directions)
interface multicycle_controller_if #(parameter int INSTR_W = 16);
   logic [INSTR_W-1:0] instruction;
   logic mem_ready;
   logic cond_true;
   logic pc_en;
   logic pc_inc_or_set;
   logic ir_en;
   logic rf_we;
   logic pc_reg_sel;
   logic r2_im_sel;
   logic [1:0] imm_type_sel;
   logic mem_req;
   logic mem_we;
   logic wb_sel;
   logic [2:0] state;
   logic fault;
   modport master (
      input instruction, mem_ready, cond_true,
      output pc_en, pc_inc_or_set, ir_en, rf_we, pc_reg_sel, r2_im_sel, imm_type_sel,
      output mem_req, mem_we, wb_sel, state, fault
   );
   modport slave (
      output instruction, mem_ready, cond_true,
      input pc_en, pc_inc_or_set, ir_en, rf_we, pc_reg_sel, r2_im_sel, imm_type_sel,
      input mem_req, mem_we, wb_sel, state, fault
   );
endinterface

// File: rtl/multicycle_controller.sv
// multicycle_controller: FETCH/DECODE/EXECUTE/MEM/WRITEBACK control FSM with memory-wait timeout
// clock: rising-edge clock; reset: synchronous active-low
// bus (master): instruction, mem_ready, cond_true in; datapath enables/selects, mem_req/mem_we, state, fault out
module multicycle_controller #(
   parameter int INSTR_W = 16,
   parameter int TIMEOUT = 15
) (
   input logic clock,
   input logic reset,
   multicycle_controller_if.master bus
);
   typedef enum logic [2:0] {
      FETCH = 3'd0, DECODE = 3'd1, EXECUTE = 3'd2, MEM = 3'd3, WRITEBACK = 3'd4, FAULT = 3'd7
   } state_t;
   state_t st;
   logic [7:0] wait_cnt;
   logic [3:0] op, ext;
   logic is_load, is_store, is_bcond, is_logic_imm, writes_rf, expired;
   assign op = bus.instruction[INSTR_W-1 -: 4];
   assign ext = bus.instruction[7:4];
   assign is_load = op == 4'h4 && ext == 4'h0;
   assign is_store = op == 4'h4 && ext == 4'h4;
   assign is_bcond = op == 4'hC;
   assign is_logic_imm = op == 4'h1 || op == 4'h2;
   assign writes_rf = op == 4'h0 || is_logic_imm || op == 4'hD || op == 4'hF || is_load;
   // this not-ready cycle is the one that brings the wait count up to TIMEOUT
   assign expired = !bus.mem_ready && wait_cnt + 8'd1 == 8'(TIMEOUT);
   always_ff @(posedge clock) begin
      if (!reset) begin
         st <= FETCH;
         wait_cnt <= '0;
      end else begin
         case (st)
            FETCH, MEM: begin
               if (bus.mem_ready) st <= st == FETCH ? DECODE : WRITEBACK;
               else if (expired) st <= FAULT;
               else wait_cnt <= wait_cnt + 8'd1;
            end
            DECODE: st <= EXECUTE;
            EXECUTE: begin
               st <= is_load || is_store ? MEM : WRITEBACK;
               wait_cnt <= '0;
            end
            WRITEBACK: begin
               st <= FETCH;
               wait_cnt <= '0;
            end
            FAULT: ;
            default: st <= FETCH;
         endcase
      end
   end
   assign bus.pc_en = st == WRITEBACK;
   assign bus.pc_inc_or_set = st == WRITEBACK && is_bcond && bus.cond_true;
   assign bus.ir_en = st == DECODE;
   assign bus.rf_we = st == WRITEBACK && writes_rf;
   assign bus.pc_reg_sel = !(st == EXECUTE && is_bcond);
   assign bus.r2_im_sel = st == EXECUTE && (is_logic_imm || op == 4'hD || op == 4'hF || is_bcond);
   assign bus.imm_type_sel = st != EXECUTE ? 2'b00 : is_logic_imm ? 2'b10 : op == 4'hF ? 2'b01 : 2'b00;
   assign bus.mem_req = st == FETCH || st == MEM;
   assign bus.mem_we = st == MEM && is_store;
   assign bus.wb_sel = st == WRITEBACK && is_load;
   assign bus.state = st;
   assign bus.fault = st == FAULT;
endmodule

// File: tb/tb_multicycle_controller.sv
// tb_multicycle_controller: directed and randomized checks of multicycle_controller against a cycle model
module tb_multicycle_controller;
   localparam int TO = 4;
   localparam logic [15:0] ORI = 16'h2123, ST = 16'h4a45, LD = 16'h4a05, BR = 16'hC012;
   logic clock = 0;
   logic reset = 0;
   int total = 0, bad = 0;
   int mph = 0, mwait = 0;
   multicycle_controller_if #(.INSTR_W(16)) bus();
   multicycle_controller #(.INSTR_W(16), .TIMEOUT(TO)) dut (.clock(clock), .reset(reset), .bus(bus));
   always #5 clock = ~clock;
   task automatic chk(input string name, input int got, input int exp);
      total++;
      if (got != exp) begin
         bad++;
         $display("FAIL %s got=%0d want=%0d t=%0t", name, got, exp, $time);
      end
   endtask
   task automatic check_model();
      logic [3:0] op, ext;
      bit ld, sto, br, wr, wb, ex;
      int imm;
      op = bus.instruction[15:12];
      ext = bus.instruction[7:4];
      ld = op == 4 && ext == 0;
      sto = op == 4 && ext == 4;
      br = op == 12;
      wr = op inside {0, 1, 2, 13, 15} || ld;
      wb = mph == 4;
      ex = mph == 2;
      imm = !ex ? 0 : op inside {1, 2} ? 2 : op == 15 ? 1 : 0;
      chk("state", int'(bus.state), mph);
      chk("pc_en", int'(bus.pc_en), int'(wb));
      chk("pc_inc_or_set", int'(bus.pc_inc_or_set), int'(wb && br && bus.cond_true));
      chk("ir_en", int'(bus.ir_en), int'(mph == 1));
      chk("rf_we", int'(bus.rf_we), int'(wb && wr));
      chk("pc_reg_sel", int'(bus.pc_reg_sel), int'(!(ex && br)));
      chk("r2_im_sel", int'(bus.r2_im_sel), int'(ex && op inside {1, 2, 12, 13, 15}));
      chk("imm_type_sel", int'(bus.imm_type_sel), imm);
      chk("mem_req", int'(bus.mem_req), int'(mph == 0 || mph == 3));
      chk("mem_we", int'(bus.mem_we), int'(mph == 3 && sto));
      chk("wb_sel", int'(bus.wb_sel), int'(wb && ld));
      chk("fault", int'(bus.fault), int'(mph == 7));
   endtask
   // model: a memory phase faults once TO consecutive cycles pass without mem_ready
   task automatic step_model();
      logic [3:0] op, ext;
      op = bus.instruction[15:12];
      ext = bus.instruction[7:4];
      if (!reset) begin
         mph = 0;
         mwait = 0;
      end else if (mph == 0 || mph == 3) begin
         if (bus.mem_ready) mph = mph == 0 ? 1 : 4;
         else begin
            mwait++;
            if (mwait == TO) mph = 7;
         end
      end else if (mph == 1) mph = 2;
      else if (mph == 2) begin
         mph = op == 4 && (ext == 0 || ext == 4) ? 3 : 4;
         mwait = 0;
      end else if (mph == 4) begin
         mph = 0;
         mwait = 0;
      end
   endtask
   task automatic cyc(input logic r, input logic [15:0] ins, input logic rdy, input logic c);
      reset = r;
      bus.instruction = ins;
      bus.mem_ready = rdy;
      bus.cond_true = c;
      #1 check_model();
      @(posedge clock);
      step_model();
      #1;
   endtask
   function automatic logic [15:0] pick();
      logic [15:0] v;
      int k;
      logic [3:0] ops [10] = '{4'h0, 4'h1, 4'h2, 4'hD, 4'hF, 4'hC, 4'h4, 4'h4, 4'h7, 4'h4};
      logic [3:0] undef [9] = '{4'h3, 4'h5, 4'h6, 4'h8, 4'h9, 4'hA, 4'hB, 4'hE, 4'h7};
      v = 16'($urandom);
      k = $urandom_range(0, 9);
      v[15:12] = k == 8 ? undef[$urandom_range(0, 8)] : ops[k];
      if (k == 6) v[7:4] = 4'h0;
      if (k == 7) v[7:4] = 4'h4;
      if (k == 9) v[7:4] = {1'b1, 3'($urandom)};
      return v;
   endfunction
   initial begin
      logic [15:0] ins;
      int n;
      bus.instruction = ORI;
      bus.mem_ready = 1;
      bus.cond_true = 0;
      @(posedge clock);
      step_model();
      #1;
      chk("rst_state", int'(bus.state), 0);
      chk("rst_mem_req", int'(bus.mem_req), 1);
      chk("rst_pc_en", int'(bus.pc_en), 0);
      chk("rst_pc_reg_sel", int'(bus.pc_reg_sel), 1);
      cyc(1, ORI, 1, 0);
      chk("ori_dec", int'(bus.state), 1);
      cyc(1, ORI, 1, 0);
      chk("ori_exe", int'(bus.state), 2);
      chk("ori_r2im", int'(bus.r2_im_sel), 1);
      chk("ori_imm", int'(bus.imm_type_sel), 2);
      cyc(1, ORI, 1, 0);
      chk("ori_wb", int'(bus.state), 4);
      chk("m_ori_wb", mph, 4);
      chk("ori_rf_we", int'(bus.rf_we), 1);
      chk("ori_pc_en", int'(bus.pc_en), 1);
      chk("ori_pc_set", int'(bus.pc_inc_or_set), 0);
      cyc(1, ORI, 1, 0);
      chk("ori_fetch", int'(bus.state), 0);
      cyc(1, ST, 1, 0);
      cyc(1, ST, 1, 0);
      cyc(1, ST, 0, 0);
      chk("st_mem", int'(bus.state), 3);
      n = 0;
      for (int k = 0; k < 4; k++) begin
         n += int'(bus.mem_req && bus.mem_we);
         cyc(1, ST, k == 3, 0);
      end
      chk("st_we_cycles", n, 4);
      chk("st_wb", int'(bus.state), 4);
      chk("st_rf_we", int'(bus.rf_we), 0);
      chk("st_pc_en", int'(bus.pc_en), 1);
      cyc(1, ST, 1, 0);
      cyc(1, LD, 1, 0);
      cyc(1, LD, 1, 0);
      cyc(1, LD, 0, 0);
      chk("ld_mem_we", int'(bus.mem_we), 0);
      chk("ld_mem_req", int'(bus.mem_req), 1);
      cyc(1, LD, 1, 0);
      chk("ld_wb_sel", int'(bus.wb_sel), 1);
      chk("ld_rf_we", int'(bus.rf_we), 1);
      cyc(1, LD, 1, 0);
      for (int c = 1; c >= 0; c--) begin
         for (int k = 0; k < 3; k++) cyc(1, BR, 1, c[0]);
         chk("br_wb", int'(bus.state), 4);
         chk("br_pc_set", int'(bus.pc_inc_or_set), c);
         chk("br_rf_we", int'(bus.rf_we), 0);
         cyc(1, BR, 1, c[0]);
      end
      for (int k = 0; k < 3; k++) cyc(1, 16'h7abc, 1, 0);
      chk("nop_wb", int'(bus.state), 4);
      chk("nop_rf_we", int'(bus.rf_we), 0);
      cyc(1, 16'h7abc, 1, 0);
      for (int k = 0; k < 3; k++) cyc(1, 16'h4a25, 1, 0);
      chk("badext_wb", int'(bus.state), 4);
      cyc(1, 16'h4a25, 1, 0);
      for (int k = 0; k < 3; k++) cyc(1, ORI, 0, 0);
      chk("to_wait3", int'(bus.state), 0);
      cyc(1, ORI, 0, 0);
      chk("to_fault_state", int'(bus.state), 7);
      chk("m_fault", mph, 7);
      chk("to_fault", int'(bus.fault), 1);
      chk("to_mem_req", int'(bus.mem_req), 0);
      cyc(1, ORI, 1, 0);
      cyc(1, ORI, 1, 0);
      chk("fault_sticky", int'(bus.state), 7);
      cyc(0, ORI, 1, 0);
      chk("fault_rst_state", int'(bus.state), 0);
      chk("fault_rst_fault", int'(bus.fault), 0);
      chk("fault_rst_req", int'(bus.mem_req), 1);
      for (int k = 0; k < 3; k++) cyc(1, ORI, 0, 0);
      cyc(1, ORI, 1, 0);
      chk("to_ready4", int'(bus.state), 1);
      chk("to_ready4_fault", int'(bus.fault), 0);
      for (int k = 0; k < 3; k++) cyc(1, LD, 1, 0);
      cyc(1, LD, 1, 0);
      cyc(1, LD, 1, 0);
      cyc(1, LD, 0, 0);
      cyc(1, LD, 0, 0);
      chk("midmem", int'(bus.state), 3);
      cyc(0, LD, 0, 0);
      chk("midmem_rst_state", int'(bus.state), 0);
      chk("midmem_rst_fault", int'(bus.fault), 0);
      chk("midmem_rst_req", int'(bus.mem_req), 1);
      ins = ORI;
      for (int i = 0; i < 4000; i++) begin
         if (mph == 0) ins = pick();
         cyc(mph == 7 ? $urandom_range(0, 3) != 0 : $urandom_range(0, 99) != 0,
             ins, $urandom_range(0, 9) < 6, 1'($urandom));
      end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule

// File: doc/multicycle_controller.md
MULTICYCLE_CONTROLLER -- requirements
Module: multicycle_controller

Interface
REQ-001 Parameter INSTR_W, default 16, instruction width; legal values >= 16.
REQ-002 Parameter TIMEOUT, default 15, maximum cycles to wait for mem_ready; legal range 1..255.
REQ-003 clock  input  1  system clock; all state updates on rising edge.
REQ-004 reset  input  1  synchronous, active-low reset, sampled on rising edge of clock.
REQ-005 instruction  input  INSTR_W  current instruction register contents.
REQ-006 mem_ready  input  1  memory completion strobe for the current mem_req.
REQ-007 cond_true  input  1  branch condition result from the external flag evaluator.
REQ-008 pc_en  output  1  PC load enable.
REQ-009 pc_inc_or_set  output  1  0 = PC+1, 1 = PC <- target.
REQ-010 ir_en  output  1  instruction register load enable.
REQ-011 rf_we  output  1  register-file write enable.
REQ-012 pc_reg_sel  output  1  ALU A source: 1 = register r1, 0 = PC.
REQ-013 r2_im_sel  output  1  ALU B source: 0 = r2, 1 = immediate.
REQ-014 imm_type_sel  output  2  00 = sign-extend, 10 = zero-extend, 01 = upper (LUI).
REQ-015 mem_req  output  1  memory access request.
REQ-016 mem_we  output  1  memory write qualifier; valid only while mem_req=1.
REQ-017 wb_sel  output  1  writeback source: 0 = ALU, 1 = memory data.
REQ-018 state  output  3  current state encoding, for debug.
REQ-019 fault  output  1  sticky memory-timeout indicator.

Function
REQ-020 States SHALL be: FETCH=0, DECODE=1, EXECUTE=2, MEM=3, WRITEBACK=4, FAULT=7; outputs are Moore, decoded from state and instruction.
REQ-021 Defaults in every state: all enables 0, pc_reg_sel=1, r2_im_sel=0, imm_type_sel=00, wb_sel=0.
REQ-022 Opcode SHALL be instruction[INSTR_W-1:INSTR_W-4]; ext field SHALL be instruction[7:4].
REQ-023 FETCH: mem_req=1, mem_we=0; go to DECODE on the cycle mem_ready=1, else stay.
REQ-024 DECODE: ir_en=1; next state is always EXECUTE.
REQ-025 EXECUTE, per opcode:
- 0000 R-type: r2_im_sel=0.
- 0001 ANDI, 0010 ORI: r2_im_sel=1, imm=10.
- 1101 MOVI: r2_im_sel=1, imm=00.
- 1111 LUI: r2_im_sel=1, imm=01.
- 1100 Bcond: pc_reg_sel=0, r2_im_sel=1, imm=00.
REQ-026 From EXECUTE, next state is MEM when opcode=0100 and ext is 0000 (LOAD) or 0100 (STORE); otherwise WRITEBACK.
REQ-027 MEM: mem_req=1, mem_we=1 for STORE, 0 for LOAD; go to WRITEBACK on mem_ready=1, else stay.
REQ-028 WRITEBACK: pc_en=1 and next state FETCH, for all instructions.
REQ-029 WRITEBACK rf_we: 1 for R-type, ANDI, ORI, MOVI, LUI and LOAD; 0 for STORE, Bcond and undefined opcodes.
REQ-030 WRITEBACK: wb_sel=1 for LOAD only.
REQ-031 WRITEBACK: pc_inc_or_set=1 only for Bcond with cond_true=1; otherwise 0.
REQ-032 Undefined opcodes/ext codes SHALL execute as NOP: FETCH -> DECODE -> EXECUTE -> WRITEBACK with only pc_en=1.
REQ-033 Wait counter (8-bit) SHALL clear on entry to FETCH or MEM and increment each cycle mem_req=1 and mem_ready=0.
REQ-034 If the wait counter equals TIMEOUT while mem_ready=0, the next state SHALL be FAULT.
REQ-035 mem_ready=1 on the same cycle the count reaches TIMEOUT SHALL take precedence: normal transition, no fault.
REQ-036 FAULT: all enables 0, mem_req=0, fault=1; remain in FAULT until reset.
REQ-037 mem_ready asserted outside FETCH/MEM SHALL be ignored.
REQ-038 Minimum latency: 4 cycles per non-memory instruction, 5 per LOAD/STORE, with zero-wait memory (mem_ready high on the first request cycle).

Reset
REQ-039 reset=0 at a rising edge SHALL force state=FETCH, clear the wait counter and clear fault, from any state including mid-MEM and FAULT.
REQ-040 Reset release: the first post-reset cycle is FETCH with mem_req=1; all other outputs are at their defaults.

Verification
REQ-041 ORI (0x2xxx), mem_ready tied 1 -> states 0,1,2,4; EXECUTE r2_im_sel=1, imm=10; WRITEBACK rf_we=1, pc_en=1, pc_inc_or_set=0.
REQ-042 STORE (0x4x4x), mem_ready delayed 3 cycles in MEM -> mem_req=1, mem_we=1 for 4 cycles; WRITEBACK rf_we=0, pc_en=1.
REQ-043 LOAD (0x4x0x) -> MEM mem_we=0; WRITEBACK wb_sel=1, rf_we=1.
REQ-044 Bcond (0xCxxx), cond_true=1 then 0 -> WRITEBACK pc_inc_or_set=1, then 0; rf_we=0 both times.
REQ-045 TIMEOUT=4, mem_ready held 0 in FETCH -> state=7 and fault=1 after 4 wait cycles; a ready-on-4th-cycle variant avoids the fault.
REQ-046 reset=0 asserted mid-MEM and while in FAULT -> next cycle state=0, fault=0, mem_req=1.
